// File: rtl/mem_bus_pkg.sv
// Shared constants for the memory-bus controller: FSM encoding, wait-counter
// width and the default region map of the ROM / I-O / RAM system.
package mem_bus_pkg;

  // Width of one per-region wait-state field and of the wait counter.
  localparam int WAIT_W = 4;

  // FSM encoding, kept as plain constants so existing code can compare
  // against raw two-bit state values.
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t RESP   = 2'd2;

  // Default region map: region index of each slave.
  localparam int ROM_REGION = 0;
  localparam int IO_REGION  = 1;
  localparam int RAM_REGION = 2;

  // Number of bits needed to hold a region index (at least one).
  function automatic int idx_width(input int num_regions);
    return (num_regions > 1) ? $clog2(num_regions) : 1;
  endfunction

endpackage

// File: rtl/mem_region_decoder.sv
// Combinational region decoder: splits a word address into a region index,
// reports whether that region exists, and whether the requested direction is
// allowed there (reads always are, writes only in writable regions).
module mem_region_decoder
  import mem_bus_pkg::*;
#(
  parameter int                     ADDR_WIDTH  = 16,
  parameter int                     REGION_BITS = 5,
  parameter int                     NUM_REGIONS = 3,
  parameter logic [NUM_REGIONS-1:0] WRITABLE    = 3'b110,
  parameter int                     IDX_W       = idx_width(NUM_REGIONS)
) (
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  we,
  output logic [IDX_W-1:0]      index,
  output logic                  mapped,
  output logic                  write_ok
);

  localparam int HI_W = ADDR_WIDTH - REGION_BITS;

  logic [HI_W-1:0] region_num;

  assign region_num = address[ADDR_WIDTH-1:REGION_BITS];

  // Match the upper address bits against every mapped region number.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    index    = '0;
    mapped   = 1'b0;
    write_ok = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (region_num == HI_W'(i)) begin
        index    = IDX_W'(i);
        mapped   = 1'b1;
        write_ok = !we || WRITABLE[i];
      end
    end
  end

endmodule

// File: rtl/mem_bus_controller.sv
// Memory-bus controller: decodes a CPU word address into one of NUM_REGIONS
// equal-size slave regions, drives a one-hot select for a per-region number
// of wait states, and answers with a one-cycle ready pulse carrying registered
// read data or a bus error for unmapped / write-protected accesses.
module mem_bus_controller
  import mem_bus_pkg::*;
#(
  parameter int                            DATA_WIDTH  = 32,
  parameter int                            ADDR_WIDTH  = 16,
  parameter int                            REGION_BITS = 5,
  parameter int                            NUM_REGIONS = 3,
  parameter logic [NUM_REGIONS*WAIT_W-1:0] WAIT_STATES = {4'd0, 4'd1, 4'd0},
  parameter logic [NUM_REGIONS-1:0]        WRITABLE    = 3'b110
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            req,
  input  logic                            we,
  input  logic [ADDR_WIDTH-1:0]           address,
  input  logic [DATA_WIDTH-1:0]           data_in,
  output logic                            ready,
  output logic                            error,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic [NUM_REGIONS-1:0]          slave_sel,
  output logic [REGION_BITS-1:0]          slave_addr,
  output logic [DATA_WIDTH-1:0]           slave_wdata,
  output logic                            slave_we,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] slave_rdata
);

  localparam int IDX_W = idx_width(NUM_REGIONS);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [IDX_W-1:0]  idx_q;
  logic              we_q;
  logic              err_q;

  logic [IDX_W-1:0]      dec_index;
  logic                  dec_mapped;
  logic                  dec_write_ok;
  logic                  access_ok;
  logic [WAIT_W-1:0]     wait_load;
  logic [DATA_WIDTH-1:0] rdata_sel;
  logic                  final_cycle;

  mem_region_decoder #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .REGION_BITS (REGION_BITS),
    .NUM_REGIONS (NUM_REGIONS),
    .WRITABLE    (WRITABLE),
    .IDX_W       (IDX_W)
  ) u_decoder (
    .address  (address),
    .we       (we),
    .index    (dec_index),
    .mapped   (dec_mapped),
    .write_ok (dec_write_ok)
  );

  // An access goes to the slave only if the region exists and permits it;
  // everything else is answered directly with an error.
  assign access_ok   = dec_mapped && dec_write_ok;
  assign wait_load   = WAIT_STATES[dec_index*WAIT_W +: WAIT_W];
  assign rdata_sel   = slave_rdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign final_cycle = (state == ACCESS) && (wait_cnt == '0);

  // FSM, wait counter, request latches and the read-data register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      slave_addr  <= '0;
      slave_wdata <= '0;
      data_out    <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      case (state)
        IDLE, RESP: begin
          // RESP accepts a new request directly, giving back-to-back
          // transactions without an IDLE bubble.
          if (req) begin
            idx_q       <= dec_index;
            we_q        <= we;
            slave_addr  <= address[REGION_BITS-1:0];
            slave_wdata <= data_in;
            if (access_ok) begin
              state    <= ACCESS;
              wait_cnt <= wait_load;
              err_q    <= 1'b0;
            end else begin
              state    <= RESP;
              wait_cnt <= '0;
              err_q    <= 1'b1;
              if (!we) begin
                data_out <= '0;
              end
            end
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          // req is ignored here: the latched transaction runs to completion.
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            state <= RESP;
            if (!we_q) begin
              data_out <= rdata_sel;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state only, so req never reaches them
  // combinationally.
  assign ready = (state == RESP);
  assign error = ready && err_q;

  // Slave strobes: select for the whole access, write only on its last cycle.
  // Both drop immediately on reset because state clears asynchronously.
  always_comb begin
    slave_sel = '0;
    if (state == ACCESS) begin
      slave_sel = NUM_REGIONS'(1) << idx_q;
    end
  end

  assign slave_we = final_cycle && we_q;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Self-checking bench for mem_bus_controller: directed cases for each region
// type, rejected accesses, back-to-back handshakes and reset mid-access,
// followed by randomized traffic against a transaction-level model.
module tb_mem_bus_controller;

  logic        clock;
  logic        reset_n;
  logic        req;
  logic        we;
  logic [15:0] address;
  logic [31:0] data_in;
  logic        ready;
  logic        error;
  logic [31:0] data_out;
  logic [2:0]  slave_sel;
  logic [4:0]  slave_addr;
  logic [31:0] slave_wdata;
  logic        slave_we;
  logic [95:0] slave_rdata;

  logic [31:0] rd_mem [3];

  // Reference view of the default map: wait states and write permission.
  int ws_tab [3] = '{0, 1, 0};
  bit wr_tab [3] = '{1'b0, 1'b1, 1'b1};

  logic [31:0] exp_dout;
  int          n_checks;
  int          n_pass;

  assign slave_rdata = {rd_mem[2], rd_mem[1], rd_mem[0]};

  mem_bus_controller dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .we          (we),
    .address     (address),
    .data_in     (data_in),
    .ready       (ready),
    .error       (error),
    .data_out    (data_out),
    .slave_sel   (slave_sel),
    .slave_addr  (slave_addr),
    .slave_wdata (slave_wdata),
    .slave_we    (slave_we),
    .slave_rdata (slave_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // One transaction from the requester's side. Called at a falling edge; the
  // request is accepted at the next rising edge and the task returns at the
  // falling edge of the ready cycle with req still high.
  task automatic run_txn(input logic w, input logic [15:0] a, input logic [31:0] d);
    int   region;
    bit   ok;
    int   lat;
    logic [2:0] exp_sel;
    region = int'(a >> 5);
    ok = 1'b0;
    if (region < 3) begin
      ok = !w || wr_tab[region];
    end
    lat = ok ? ws_tab[region] + 2 : 1;
    exp_sel = ok ? 3'(1 << region) : 3'b000;
    for (int r = 0; r < 3; r++) rd_mem[r] = $urandom;
    req     = 1'b1;
    we      = w;
    address = a;
    data_in = d;
    @(posedge clock);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clock);
      if (c < lat) begin
        check("acc_sel",   {29'd0, slave_sel}, {29'd0, exp_sel});
        check("acc_we",    {31'd0, slave_we}, {31'd0, (w && c == lat - 1)});
        check("acc_addr",  {27'd0, slave_addr}, {27'd0, a[4:0]});
        check("acc_ready", {31'd0, ready}, 32'd0);
        if (w) check("acc_wdata", slave_wdata, d);
        // Inputs change while the access runs; the latched request must win.
        address = 16'($urandom);
        we      = 1'($urandom);
        data_in = $urandom;
      end else begin
        if (!w) exp_dout = ok ? rd_mem[region] : 32'd0;
        check("rsp_ready", {31'd0, ready}, 32'd1);
        check("rsp_error", {31'd0, error}, {31'd0, !ok});
        check("rsp_sel",   {29'd0, slave_sel}, 32'd0);
        check("rsp_we",    {31'd0, slave_we}, 32'd0);
        check("rsp_dout",  data_out, exp_dout);
      end
    end
  endtask

  // Drop req for one cycle and confirm the bus is quiet.
  task automatic idle_cycle();
    req = 1'b0;
    @(negedge clock);
    check("idle_ready", {31'd0, ready}, 32'd0);
    check("idle_sel",   {29'd0, slave_sel}, 32'd0);
    check("idle_dout",  data_out, exp_dout);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_dout = '0;
    reset_n  = 1'b0;
    req      = 1'b0;
    we       = 1'b0;
    address  = '0;
    data_in  = '0;
    for (int r = 0; r < 3; r++) rd_mem[r] = '0;

    #12;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_dout",  data_out, 32'd0);
    check("rst_sel",   {29'd0, slave_sel}, 32'd0);
    check("rst_we",    {31'd0, slave_we}, 32'd0);
    check("rst_addr",  {27'd0, slave_addr}, 32'd0);
    check("rst_wdata", slave_wdata, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed cases.
    run_txn(1'b0, 16'h0005, 32'h0);          // ROM read, W=0
    idle_cycle();
    run_txn(1'b1, 16'h0023, 32'h0000000A);   // I/O write, W=1
    idle_cycle();
    run_txn(1'b1, 16'h0002, 32'h12345678);   // write to ROM: rejected
    idle_cycle();
    run_txn(1'b0, 16'h0060, 32'h0);          // unmapped read
    idle_cycle();
    run_txn(1'b0, 16'h0041, 32'h0);          // RAM read ...
    run_txn(1'b1, 16'h0042, 32'hCAFEF00D);   // ... then RAM write back-to-back
    run_txn(1'b0, 16'h8040, 32'h0);          // unmapped read back-to-back
    idle_cycle();

    // Reset during the final cycle of an I/O write.
    req = 1'b1; we = 1'b1; address = 16'h0023; data_in = 32'h00000005;
    @(posedge clock);
    @(negedge clock);
    check("mid_sel1", {29'd0, slave_sel}, 32'd2);
    check("mid_we1",  {31'd0, slave_we}, 32'd0);
    @(posedge clock);
    #2;
    check("mid_we2",  {31'd0, slave_we}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_sel",   {29'd0, slave_sel}, 32'd0);
    check("mid_rst_we",    {31'd0, slave_we}, 32'd0);
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_dout",  data_out, 32'd0);
    check("mid_rst_wdata", slave_wdata, 32'd0);
    req = 1'b0;
    exp_dout = '0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("post_rst_ready", {31'd0, ready}, 32'd0);
    end

    // Randomized traffic: mapped regions, region edges and arbitrary addresses.
    for (int t = 0; t < 80; t++) begin
      logic [15:0] a;
      case ($urandom_range(0, 4))
        0, 1, 2: a = 16'(($urandom_range(0, 2) << 5) | $urandom_range(0, 31));
        3:       a = 16'($urandom_range(16'h005E, 16'h0062));
        default: a = 16'($urandom);
      endcase
      run_txn(1'($urandom), a, $urandom);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
